stream_mem_server: RTL and testbench



---
 rtl/stream_mem_server.sv | 206 ++++++++++++++++++++
 tb/tb_stream_mem_server.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mem_server.sv
// Memory-side endpoint: request stream in, one word command per beat out, read data back as a response stream.
// Reads are credit-limited to RESP_DEPTH so the response FIFO can never overflow.

module stream_mem_server_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + AW'(1);
            if (i_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, i_pop};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wptr] <= i_dat;
    end

    assign o_dat   = r_mem[r_rptr];
    assign o_empty = (r_count == '0);
endmodule

module stream_mem_server #(
    parameter int RESP_DEPTH = 4
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [127:0] req_axis_data,
    input  logic         req_axis_tuser,
    input  logic         req_axis_valid,
    output logic         req_axis_ready,
    output logic [127:0] resp_axis_data,
    output logic         resp_axis_tuser,
    output logic         resp_axis_valid,
    input  logic         resp_axis_ready,
    output logic [26:0]  mem_addr,
    output logic [127:0] mem_wdata,
    output logic         mem_wen,
    output logic         mem_valid,
    input  logic         mem_ready,
    input  logic [127:0] mem_rdata,
    input  logic         mem_rvalid,
    output logic         proto_err,
    output logic         busy
);
    localparam int CW = $clog2(RESP_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    state_t         r_state, w_state_nxt;
    logic [26:0]    r_cur_addr, w_addr_nxt;
    logic [26:0]    r_remaining, w_rem_nxt;
    logic [CW-1:0]  r_credits;
    logic           r_first_pending, w_first_nxt;
    logic           r_proto_err, w_err_nxt;

    logic           w_run;
    logic           w_req_rdy, w_mem_vld, w_mem_wen, w_hdr_take;
    logic           w_rd_issue, w_pop;
    logic           w_tag;
    logic           w_tagq_empty_unused;
    logic [128:0]   w_fifo_dat;
    logic           w_fifo_empty;

    logic           w_hdr_wen;
    logic [26:0]    w_hdr_len, w_hdr_addr;

    assign w_run      = ~rst_in;
    assign w_hdr_wen  = req_axis_data[0];
    assign w_hdr_len  = req_axis_data[27:1];
    assign w_hdr_addr = req_axis_data[54:28];

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_cur_addr;
        w_rem_nxt   = r_remaining;
        w_first_nxt = r_first_pending;
        w_err_nxt   = r_proto_err;
        w_req_rdy   = 1'b0;
        w_mem_vld   = 1'b0;
        w_mem_wen   = 1'b0;
        w_hdr_take  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_rdy = 1'b1;
                if (req_axis_valid) begin
                    if (req_axis_tuser) w_hdr_take = 1'b1;
                    else                w_err_nxt  = 1'b1;
                end
            end
            S_RD: begin
                w_mem_vld = (r_credits != '0);
                if (w_mem_vld && mem_ready) begin
                    w_addr_nxt  = r_cur_addr + 27'd1;
                    w_rem_nxt   = r_remaining - 27'd1;
                    w_first_nxt = 1'b0;
                    if (r_remaining == 27'd1) w_state_nxt = S_IDLE;
                end
            end
            S_WR: begin
                w_mem_wen = 1'b1;
                // A header mid-burst abandons the rest of the write and starts over.
                if (req_axis_valid && req_axis_tuser) begin
                    w_req_rdy  = 1'b1;
                    w_hdr_take = 1'b1;
                    w_err_nxt  = 1'b1;
                end else begin
                    w_mem_vld = req_axis_valid;
                    w_req_rdy = mem_ready;
                    if (req_axis_valid && mem_ready) begin
                        w_addr_nxt = r_cur_addr + 27'd1;
                        w_rem_nxt  = r_remaining - 27'd1;
                        if (r_remaining == 27'd1) w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_hdr_take) begin
            w_addr_nxt = w_hdr_addr;
            w_rem_nxt  = w_hdr_len;
            if (w_hdr_len == 27'd0) begin
                w_state_nxt = S_IDLE;
            end else if (w_hdr_wen) begin
                w_state_nxt = S_WR;
            end else begin
                w_state_nxt = S_RD;
                w_first_nxt = 1'b1;
            end
        end
    end

    assign w_rd_issue = (r_state == S_RD) && w_mem_vld && mem_ready;
    assign w_pop      = resp_axis_valid && resp_axis_ready;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state         <= S_IDLE;
            r_cur_addr      <= '0;
            r_remaining     <= '0;
            r_credits       <= CW'(RESP_DEPTH);
            r_first_pending <= 1'b0;
            r_proto_err     <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cur_addr      <= w_addr_nxt;
            r_remaining     <= w_rem_nxt;
            r_first_pending <= w_first_nxt;
            r_proto_err     <= w_err_nxt;
            r_credits       <= r_credits + {{(CW-1){1'b0}}, w_pop}
                                         - {{(CW-1){1'b0}}, w_rd_issue};
        end
    end

    // First-beat tag follows each read command until its data returns.
    stream_mem_server_fifo #(.WIDTH(1), .DEPTH(RESP_DEPTH)) u_tag_q (
        .i_clk   (clk_in),
        .i_rst   (rst_in),
        .i_push  (w_rd_issue),
        .i_dat   (r_first_pending),
        .i_pop   (mem_rvalid & w_run),
        .o_dat   (w_tag),
        .o_empty (w_tagq_empty_unused)
    );

    stream_mem_server_fifo #(.WIDTH(129), .DEPTH(RESP_DEPTH)) u_resp_q (
        .i_clk   (clk_in),
        .i_rst   (rst_in),
        .i_push  (mem_rvalid & w_run),
        .i_dat   ({w_tag, mem_rdata}),
        .i_pop   (w_pop),
        .o_dat   (w_fifo_dat),
        .o_empty (w_fifo_empty)
    );

    assign req_axis_ready  = w_run & w_req_rdy;
    assign mem_valid       = w_run & w_mem_vld;
    assign mem_wen         = w_run & w_mem_wen;
    assign mem_addr        = r_cur_addr & {27{w_run}};
    assign mem_wdata       = req_axis_data & {128{w_run}};
    assign resp_axis_valid = w_run & ~w_fifo_empty;
    assign resp_axis_tuser = w_run & ~w_fifo_empty & w_fifo_dat[128];
    assign resp_axis_data  = w_fifo_dat[127:0] & {128{w_run}};
    assign proto_err       = w_run & r_proto_err;
    assign busy            = w_run & ((r_state != S_IDLE) || (r_credits != CW'(RESP_DEPTH)));
endmodule

// File: tb/tb_stream_mem_server.sv
// Directed bench for stream_mem_server: in-order memory model with 2-cycle read latency,
// handshake monitor on the falling edge, hand-computed expected commands and responses.

module tb_stream_mem_server;
    logic         clk_in;
    logic         rst_in;
    logic [127:0] req_axis_data;
    logic         req_axis_tuser;
    logic         req_axis_valid;
    logic         req_axis_ready;
    logic [127:0] resp_axis_data;
    logic         resp_axis_tuser;
    logic         resp_axis_valid;
    logic         resp_axis_ready;
    logic [26:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_wen;
    logic         mem_valid;
    logic         mem_ready  = 1'b1;
    logic [127:0] mem_rdata  = '0;
    logic         mem_rvalid = 1'b0;
    logic         proto_err;
    logic         busy;

    stream_mem_server #(.RESP_DEPTH(4)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .req_axis_data   (req_axis_data),
        .req_axis_tuser  (req_axis_tuser),
        .req_axis_valid  (req_axis_valid),
        .req_axis_ready  (req_axis_ready),
        .resp_axis_data  (resp_axis_data),
        .resp_axis_tuser (resp_axis_tuser),
        .resp_axis_valid (resp_axis_valid),
        .resp_axis_ready (resp_axis_ready),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_wen         (mem_wen),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .mem_rdata       (mem_rdata),
        .mem_rvalid      (mem_rvalid),
        .proto_err       (proto_err),
        .busy            (busy)
    );

    typedef struct {
        logic         wen;
        logic [26:0]  addr;
        logic [127:0] wdata;
        int           cyc;
    } cmd_t;
    typedef struct {
        logic         tuser;
        logic [127:0] data;
    } resp_t;
    typedef struct {
        logic [26:0] addr;
        int          due;
    } rd_t;

    cmd_t  cmd_q[$];
    resp_t resp_q[$];
    rd_t   memq[$];
    int    cyc = 0;
    int    rd_idx = 0;
    int    n_rv = 0;
    int    n_out = 0;
    int    max_out = 0;
    int    hdr_cyc = 0;
    int    mem_mode = 0;
    int    n_vec = 0;
    int    n_bad = 0;

    function automatic logic [127:0] hdr(input logic [26:0] a, input logic [26:0] len, input logic wen);
        hdr = {73'd0, a, len, wen};
    endfunction

    function automatic logic [127:0] pat(input logic [26:0] a);
        pat = {5'h15, a, 5'h0A, a, 5'h15, a, 5'h0A, a};
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1);
    end

    // Memory model: in-order reads, data returned two edges after acceptance.
    always @(posedge clk_in) begin
        cyc = cyc + 1;
        #1;
        if (rst_in) begin
            rd_idx     = memq.size();
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end else if (rd_idx < memq.size() && memq[rd_idx].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pat(memq[rd_idx].addr);
            rd_idx     = rd_idx + 1;
            n_rv       = n_rv + 1;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
        mem_ready = (mem_mode == 1) ? cyc[0] : 1'b1;
    end

    always @(negedge clk_in) begin
        cmd_t  c;
        resp_t r;
        rd_t   m;
        if (rst_in) begin
            n_out = 0;
        end else begin
            if (req_axis_valid && req_axis_ready && req_axis_tuser) hdr_cyc = cyc;
            if (mem_valid && mem_ready) begin
                c.wen = mem_wen; c.addr = mem_addr; c.wdata = mem_wdata; c.cyc = cyc;
                cmd_q.push_back(c);
                if (!mem_wen) begin
                    m.addr = mem_addr; m.due = cyc + 2;
                    memq.push_back(m);
                    n_out = n_out + 1;
                end
            end
            if (resp_axis_valid && resp_axis_ready) begin
                r.tuser = resp_axis_tuser; r.data = resp_axis_data;
                resp_q.push_back(r);
                n_out = n_out - 1;
            end
            if (n_out > max_out) max_out = n_out;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input string tag, input logic tuser, input logic [127:0] dat);
        bit ok;
        ok = 0;
        req_axis_valid = 1'b1;
        req_axis_tuser = tuser;
        req_axis_data  = dat;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_in);
            if (req_axis_ready) ok = 1;
            @(posedge clk_in);
            #1;
        end
        req_axis_valid = 1'b0;
        req_axis_tuser = 1'b0;
        check_eq({tag, "_accept"}, ok, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk_in);
            if (!busy && !resp_axis_valid) ok = 1;
        end
        @(posedge clk_in);
        #1;
        check_eq({tag, "_idle"}, ok, 1'b1);
    endtask

    task automatic check_reads(input string tag, input int cb, input int rb, input logic [26:0] a0, input int n);
        logic [26:0] a;
        check_eq({tag, "_ncmd"}, cmd_q.size() - cb, n);
        check_eq({tag, "_nresp"}, resp_q.size() - rb, n);
        for (int i = 0; i < n; i++) begin
            a = a0 + 27'(i);
            if (cb + i < cmd_q.size()) begin
                check_eq($sformatf("%s_addr%0d", tag, i), cmd_q[cb+i].addr, a);
                check_eq($sformatf("%s_wen%0d", tag, i), cmd_q[cb+i].wen, 1'b0);
            end
            if (rb + i < resp_q.size()) begin
                check_eq($sformatf("%s_data%0d", tag, i), resp_q[rb+i].data, pat(a));
                check_eq($sformatf("%s_tuser%0d", tag, i), resp_q[rb+i].tuser, (i == 0));
            end
        end
    endtask

    initial begin
        int cb, rb, v0;
        logic [127:0] wd [4];
        wd[0] = 128'hD0D0_0000_1111_2222_3333_4444_5555_0000;
        wd[1] = 128'hD1D1_0000_1111_2222_3333_4444_5555_0001;
        wd[2] = 128'hD2D2_0000_1111_2222_3333_4444_5555_0002;
        wd[3] = 128'hD3D3_0000_1111_2222_3333_4444_5555_0003;

        rst_in = 1'b1;
        req_axis_valid = 1'b0; req_axis_tuser = 1'b0; req_axis_data = '0;
        resp_axis_ready = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        req_axis_valid = 1'b1; req_axis_tuser = 1'b1; req_axis_data = hdr(27'h100, 27'd4, 1'b0);
        @(negedge clk_in);
        check_eq("rst_req_ready", req_axis_ready, 1'b0);
        check_eq("rst_mem_valid", mem_valid, 1'b0);
        check_eq("rst_resp_valid", resp_axis_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_mem_wdata", mem_wdata, 128'd0);
        @(posedge clk_in);
        #1;
        req_axis_valid = 1'b0; req_axis_tuser = 1'b0;
        rst_in = 1'b0;
        @(negedge clk_in);
        check_eq("post_rst_req_ready", req_axis_ready, 1'b1);
        check_eq("post_rst_busy", busy, 1'b0);
        check_eq("post_rst_proto_err", proto_err, 1'b0);
        @(posedge clk_in);
        #1;

        // Read burst, 4 beats from 0x100.
        cb = cmd_q.size(); rb = resp_q.size();
        send_beat("t1_hdr", 1'b1, hdr(27'h100, 27'd4, 1'b0));
        wait_idle("t1");
        check_reads("t1", cb, rb, 27'h100, 4);
        if (cmd_q.size() > cb) check_eq("t1_first_cmd_lat", cmd_q[cb].cyc - hdr_cyc, 1);
        for (int i = 1; i < 4; i++)
            if (cb + i < cmd_q.size())
                check_eq($sformatf("t1_back2back%0d", i), cmd_q[cb+i].cyc - cmd_q[cb].cyc, i);

        // Write burst with memory backpressure toggling.
        mem_mode = 1;
        cb = cmd_q.size(); rb = resp_q.size();
        send_beat("t2_hdr", 1'b1, hdr(27'h20, 27'd4, 1'b1));
        for (int i = 0; i < 4; i++) send_beat($sformatf("t2_d%0d", i), 1'b0, wd[i]);
        wait_idle("t2");
        mem_mode = 0;
        check_eq("t2_ncmd", cmd_q.size() - cb, 4);
        for (int i = 0; i < 4; i++) begin
            if (cb + i < cmd_q.size()) begin
                check_eq($sformatf("t2_wen%0d", i), cmd_q[cb+i].wen, 1'b1);
                check_eq($sformatf("t2_addr%0d", i), cmd_q[cb+i].addr, 27'h20 + 27'(i));
                check_eq($sformatf("t2_wdata%0d", i), cmd_q[cb+i].wdata, wd[i]);
            end
        end
        check_eq("t2_nresp", resp_q.size() - rb, 0);
        check_eq("t2_proto_err", proto_err, 1'b0);

        // Credit limit: responses held off, only RESP_DEPTH reads may issue.
        resp_axis_ready = 1'b0;
        cb = cmd_q.size(); rb = resp_q.size();
        send_beat("t3_hdr", 1'b1, hdr(27'h200, 27'd8, 1'b0));
        repeat (20) @(negedge clk_in);
        check_eq("t3_stall_ncmd", cmd_q.size() - cb, 4);
        check_eq("t3_stall_mem_valid", mem_valid, 1'b0);
        check_eq("t3_stall_resp_valid", resp_axis_valid, 1'b1);
        check_eq("t3_stall_busy", busy, 1'b1);
        @(posedge clk_in);
        #1;
        resp_axis_ready = 1'b1;
        wait_idle("t3");
        check_reads("t3", cb, rb, 27'h200, 8);
        check_eq("t3_max_outstanding", max_out, 4);

        // Address wrap at the top of the 27-bit space.
        cb = cmd_q.size(); rb = resp_q.size();
        send_beat("t4_hdr", 1'b1, hdr(27'h7FFFFFE, 27'd4, 1'b0));
        wait_idle("t4");
        check_reads("t4", cb, rb, 27'h7FFFFFE, 4);
        if (cb + 2 < cmd_q.size()) check_eq("t4_wrap_zero", cmd_q[cb+2].addr, 27'h0);

        // Stray data beat, then a write cut short by a read header.
        cb = cmd_q.size(); rb = resp_q.size();
        send_beat("t5_stray", 1'b0, 128'hBAD);
        @(negedge clk_in);
        check_eq("t5_proto_err_stray", proto_err, 1'b1);
        check_eq("t5_stray_no_cmd", cmd_q.size() - cb, 0);
        @(posedge clk_in);
        #1;
        send_beat("t5_whdr", 1'b1, hdr(27'h40, 27'd4, 1'b1));
        send_beat("t5_d0", 1'b0, wd[0]);
        send_beat("t5_d1", 1'b0, wd[1]);
        send_beat("t5_rhdr", 1'b1, hdr(27'h300, 27'd1, 1'b0));
        wait_idle("t5");
        check_eq("t5_ncmd", cmd_q.size() - cb, 3);
        if (cb + 2 < cmd_q.size()) begin
            check_eq("t5_w0_addr", cmd_q[cb].addr, 27'h40);
            check_eq("t5_w0_data", cmd_q[cb].wdata, wd[0]);
            check_eq("t5_w1_addr", cmd_q[cb+1].addr, 27'h41);
            check_eq("t5_w1_wen", cmd_q[cb+1].wen, 1'b1);
            check_eq("t5_rd_addr", cmd_q[cb+2].addr, 27'h300);
            check_eq("t5_rd_wen", cmd_q[cb+2].wen, 1'b0);
        end
        check_eq("t5_nresp", resp_q.size() - rb, 1);
        if (rb < resp_q.size()) begin
            check_eq("t5_resp_data", resp_q[rb].data, pat(27'h300));
            check_eq("t5_resp_tuser", resp_q[rb].tuser, 1'b1);
        end
        check_eq("t5_proto_err", proto_err, 1'b1);
        cb = cmd_q.size();
        send_beat("t5_zero", 1'b1, hdr(27'h999, 27'd0, 1'b0));
        @(negedge clk_in);
        check_eq("t5_zero_mem_valid", mem_valid, 1'b0);
        check_eq("t5_zero_busy", busy, 1'b0);
        check_eq("t5_zero_req_ready", req_axis_ready, 1'b1);
        repeat (3) @(negedge clk_in);
        check_eq("t5_zero_ncmd", cmd_q.size() - cb, 0);
        @(posedge clk_in);
        #1;

        // Reset in the middle of a read burst with two beats buffered.
        resp_axis_ready = 1'b0;
        v0 = n_rv;
        send_beat("t6_hdr", 1'b1, hdr(27'h400, 27'd8, 1'b0));
        for (int i = 0; i < 50 && (n_rv - v0) < 2; i++) @(negedge clk_in);
        check_eq("t6_two_returned", n_rv - v0, 2);
        @(posedge clk_in);
        #1;
        check_eq("t6_pre_rst_resp_valid", resp_axis_valid, 1'b1);
        check_eq("t6_pre_rst_busy", busy, 1'b1);
        rst_in = 1'b1;
        req_axis_data = '1;
        #1;
        check_eq("t6_rst_req_ready", req_axis_ready, 1'b0);
        check_eq("t6_rst_mem_valid", mem_valid, 1'b0);
        check_eq("t6_rst_resp_valid", resp_axis_valid, 1'b0);
        check_eq("t6_rst_resp_data", resp_axis_data, 128'd0);
        check_eq("t6_rst_mem_addr", mem_addr, 27'd0);
        check_eq("t6_rst_mem_wdata", mem_wdata, 128'd0);
        check_eq("t6_rst_busy", busy, 1'b0);
        check_eq("t6_rst_proto_err", proto_err, 1'b0);
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        req_axis_data = '0;
        resp_axis_ready = 1'b1;
        @(negedge clk_in);
        check_eq("t6_post_busy", busy, 1'b0);
        check_eq("t6_post_resp_valid", resp_axis_valid, 1'b0);
        check_eq("t6_post_req_ready", req_axis_ready, 1'b1);
        @(posedge clk_in);
        #1;
        cb = cmd_q.size(); rb = resp_q.size();
        send_beat("t6_new_hdr", 1'b1, hdr(27'h500, 27'd1, 1'b0));
        wait_idle("t6");
        check_reads("t6", cb, rb, 27'h500, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
